// File: rtl/fp16_mul_arbiter.sv
// Two-requester round-robin front end for a shared fixed-latency binary16 multiplier.
// Per-requester credit (buffer space minus in-flight work) gates issue so FIFOs never overflow.
module fp16_mul_arbiter #(
    parameter int unsigned LAT   = 1,
    parameter int unsigned DEPTH = 2
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        req_valid_0,
    input  logic        req_valid_1,
    output logic        req_ready_0,
    output logic        req_ready_1,
    input  logic [15:0] req_a_0,
    input  logic [15:0] req_b_0,
    input  logic [15:0] req_a_1,
    input  logic [15:0] req_b_1,
    output logic        rsp_valid_0,
    output logic        rsp_valid_1,
    input  logic        rsp_ready_0,
    input  logic        rsp_ready_1,
    output logic [15:0] rsp_data_0,
    output logic [15:0] rsp_data_1,
    output logic [15:0] mul_a,
    output logic [15:0] mul_b,
    input  logic [15:0] mul_out,
    output logic        busy
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = 3;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [1:0]    req_valid, rsp_ready, eligible, grant, push, pop;
    logic [15:0]   req_a [2];
    logic [15:0]   req_b [2];
    logic [CW-1:0] count_q [2];
    logic [CW-1:0] inflight_q [2];
    logic [CW-1:0] credit [2];
    logic [PW-1:0] rd_ptr_q [2];
    logic [PW-1:0] wr_ptr_q [2];
    logic [15:0]   mem_q [2][DEPTH];
    logic [LAT-1:0] trk_v_q, trk_id_q;
    logic          ptr_q;
    logic          gnt_id;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign req_valid = {req_valid_1, req_valid_0};
    assign rsp_ready = {rsp_ready_1, rsp_ready_0};
    assign req_a[0]  = req_a_0;
    assign req_a[1]  = req_a_1;
    assign req_b[0]  = req_b_0;
    assign req_b[1]  = req_b_1;

    always_comb begin
        eligible = '0;
        push     = '0;
        pop      = '0;
        for (int i = 0; i < 2; i++) begin
            credit[i]   = DEPTH_C - (inflight_q[i] + count_q[i]);
            eligible[i] = req_valid[i] && (credit[i] != '0) && !RESET;
            push[i]     = trk_v_q[LAT-1] && (trk_id_q[LAT-1] == 1'(i));
            pop[i]      = (count_q[i] != '0) && rsp_ready[i];
        end
    end

    // Contention resolved by the pointer; a lone eligible requester always wins.
    always_comb begin
        grant = '0;
        if (eligible == 2'b11) begin
            grant[ptr_q] = 1'b1;
        end else begin
            grant = eligible;
        end
        gnt_id = grant[1];
    end

    assign req_ready_0 = grant[0];
    assign req_ready_1 = grant[1];
    assign mul_a       = (grant != '0) ? req_a[gnt_id] : 16'h0000;
    assign mul_b       = (grant != '0) ? req_b[gnt_id] : 16'h0000;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            trk_v_q  <= '0;
            trk_id_q <= '0;
            ptr_q    <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                count_q[i]    <= '0;
                inflight_q[i] <= '0;
                rd_ptr_q[i]   <= '0;
                wr_ptr_q[i]   <= '0;
            end
        end else begin
            trk_v_q[0]  <= |grant;
            trk_id_q[0] <= gnt_id;
            for (int k = 1; k < LAT; k++) begin
                trk_v_q[k]  <= trk_v_q[k-1];
                trk_id_q[k] <= trk_id_q[k-1];
            end
            if (|grant) begin
                ptr_q <= ~gnt_id;
            end
            for (int i = 0; i < 2; i++) begin
                inflight_q[i] <= inflight_q[i] + CW'(grant[i]) - CW'(push[i]);
                count_q[i]    <= count_q[i] + CW'(push[i]) - CW'(pop[i]);
                if (push[i]) begin
                    mem_q[i][wr_ptr_q[i]] <= mul_out;
                    wr_ptr_q[i]           <= ptr_inc(wr_ptr_q[i]);
                end
                if (pop[i]) begin
                    rd_ptr_q[i] <= ptr_inc(rd_ptr_q[i]);
                end
            end
        end
    end

    assign rsp_valid_0 = (count_q[0] != '0);
    assign rsp_valid_1 = (count_q[1] != '0);
    assign rsp_data_0  = mem_q[0][rd_ptr_q[0]];
    assign rsp_data_1  = mem_q[1][rd_ptr_q[1]];
    assign busy        = (|trk_v_q) || rsp_valid_0 || rsp_valid_1;

    // Credit accounting must keep reserved space within the buffer.
    a_no_ovf_0: assert property (@(posedge CLK) disable iff (RESET)
        ({1'b0, inflight_q[0]} + {1'b0, count_q[0]}) <= {1'b0, DEPTH_C});
    a_no_ovf_1: assert property (@(posedge CLK) disable iff (RESET)
        ({1'b0, inflight_q[1]} + {1'b0, count_q[1]}) <= {1'b0, DEPTH_C});

endmodule

// File: tb/tb_fp16_mul_arbiter.sv
// Scoreboard bench: accepts push expected products, a negedge monitor pops and compares responses.
module tb_fp16_mul_arbiter;

    localparam int unsigned LAT   = 1;
    localparam int unsigned DEPTH = 2;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        req_valid_0 = 0, req_valid_1 = 0;
    logic        req_ready_0, req_ready_1;
    logic [15:0] req_a_0 = 0, req_b_0 = 0, req_a_1 = 0, req_b_1 = 0;
    logic        rsp_valid_0, rsp_valid_1;
    logic        rsp_ready_0 = 0, rsp_ready_1 = 0;
    logic [15:0] rsp_data_0, rsp_data_1;
    logic [15:0] mul_a, mul_b, mul_out;
    logic        busy;

    fp16_mul_arbiter #(.LAT(LAT), .DEPTH(DEPTH)) dut (
        .CLK(CLK), .RESET(RESET),
        .req_valid_0(req_valid_0), .req_valid_1(req_valid_1),
        .req_ready_0(req_ready_0), .req_ready_1(req_ready_1),
        .req_a_0(req_a_0), .req_b_0(req_b_0), .req_a_1(req_a_1), .req_b_1(req_b_1),
        .rsp_valid_0(rsp_valid_0), .rsp_valid_1(rsp_valid_1),
        .rsp_ready_0(rsp_ready_0), .rsp_ready_1(rsp_ready_1),
        .rsp_data_0(rsp_data_0), .rsp_data_1(rsp_data_1),
        .mul_a(mul_a), .mul_b(mul_b), .mul_out(mul_out), .busy(busy)
    );

    always #5 CLK = ~CLK;

    // Stand-in multiplier: hand-computed table for the operand pairs used here.
    function automatic logic [15:0] fmul(input logic [15:0] a, input logic [15:0] b);
        case ({a, b})
            32'h3C00_4000, 32'h4000_3C00: return 16'h4000;
            32'h3C00_3C00:                return 16'h3C00;
            32'h4000_4000:                return 16'h4400;
            32'h4200_3800, 32'h3800_4200: return 16'h3E00;
            32'h0000_0000:                return 16'h0000;
            default:                      return 16'hDEAD;
        endcase
    endfunction

    logic [15:0] mpipe [LAT];
    always @(posedge CLK) begin
        mpipe[0] <= fmul(mul_a, mul_b);
        for (int k = 1; k < LAT; k++) mpipe[k] <= mpipe[k-1];
    end
    assign mul_out = mpipe[LAT-1];

    typedef struct packed {
        logic [15:0] d;
        int          c;
    } ent_t;

    ent_t q0[$];
    ent_t q1[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   acc0 = 0, acc1 = 0;
    logic [15:0] exp0 = 0, exp1 = 0;
    bit   alt_phase = 0, starve_phase = 0, lat_exact = 0, exp_gnt = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    task automatic rsp_chk(input int id, input logic [15:0] d);
        ent_t e;
        if ((id == 0 && q0.size() == 0) || (id == 1 && q1.size() == 0)) begin
            n_checks++;
            n_fail++;
            $display("FAIL rsp_unexpected_%0d: got %h expected no response", id, d);
        end else begin
            e = (id == 0) ? q0.pop_front() : q1.pop_front();
            check($sformatf("rsp_data_%0d", id), int'(d), int'(e.d));
            if (lat_exact) check("lat_exact", cyc - e.c, LAT + 1);
            else           check("lat_min", int'((cyc - e.c) >= LAT + 1), 1);
        end
    endtask

    always @(negedge CLK) begin
        if (RESET) begin
            q0.delete();
            q1.delete();
        end else begin
            if (req_valid_0 && req_ready_0) begin q0.push_back('{exp0, cyc}); acc0++; end
            if (req_valid_1 && req_ready_1) begin q1.push_back('{exp1, cyc}); acc1++; end
            if (alt_phase) begin
                check("rr_ready_0", int'(req_ready_0), int'(exp_gnt == 1'b0));
                check("rr_ready_1", int'(req_ready_1), int'(exp_gnt == 1'b1));
                check("rr_mul_a", int'(mul_a), 'h3C00);
                exp_gnt = ~exp_gnt;
            end
            if (starve_phase) check("starve_ready_1", int'(req_ready_1), 0);
            if (rsp_valid_0 && rsp_ready_0) rsp_chk(0, rsp_data_0);
            if (rsp_valid_1 && rsp_ready_1) rsp_chk(1, rsp_data_1);
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 50; k++) begin
            @(negedge CLK);
            if (!busy) break;
        end
        check("drain_busy", int'(busy), 0);
        tick();
    endtask

    task automatic issue0(input logic [15:0] a, input logic [15:0] b, input logic [15:0] e);
        bit ok = 0;
        req_a_0 = a; req_b_0 = b; exp0 = e; req_valid_0 = 1;
        for (int k = 0; k < 30; k++) begin
            @(negedge CLK);
            if (req_ready_0) begin ok = 1; break; end
        end
        check("issue0_accept", int'(ok), 1);
        tick();
        req_valid_0 = 0;
    endtask

    int base0, base1;

    initial begin
        // Reset with requests pending: nothing may be granted or driven.
        req_a_0 = 16'h3C00; req_b_0 = 16'h4000; req_a_1 = 16'h3C00; req_b_1 = 16'h4000;
        req_valid_0 = 1; req_valid_1 = 1;
        tick(); tick();
        @(negedge CLK);
        check("rst_ready_0", int'(req_ready_0), 0);
        check("rst_ready_1", int'(req_ready_1), 0);
        check("rst_mul_a", int'(mul_a), 0);
        check("rst_mul_b", int'(mul_b), 0);
        tick();
        RESET = 0; req_valid_0 = 0; req_valid_1 = 0;
        @(negedge CLK);
        check("rst_rsp_valid_0", int'(rsp_valid_0), 0);
        check("rst_rsp_valid_1", int'(rsp_valid_1), 0);
        check("rst_busy", int'(busy), 0);
        tick();

        // Alternating grants, 3C00 x 4000 = 4000, latency LAT+1.
        exp0 = 16'h4000; exp1 = 16'h4000;
        rsp_ready_0 = 1; rsp_ready_1 = 1;
        exp_gnt = 0; alt_phase = 1; lat_exact = 1;
        req_valid_0 = 1; req_valid_1 = 1;
        repeat (8) tick();
        req_valid_0 = 0; req_valid_1 = 0; alt_phase = 0;
        wait_idle();
        lat_exact = 0;

        // Credit exhaustion with responses held, then a one-cycle pop.
        base0 = acc0;
        req_a_0 = 16'h3C00; req_b_0 = 16'h3C00; exp0 = 16'h3C00;
        rsp_ready_0 = 0; req_valid_0 = 1;
        repeat (6) tick();
        check("credit_accepts", acc0 - base0, DEPTH);
        @(negedge CLK);
        check("credit_block", int'(req_ready_0), 0);
        tick();
        rsp_ready_0 = 1;
        @(negedge CLK);
        check("no_bypass", int'(req_ready_0), 0);
        tick();
        rsp_ready_0 = 0;
        @(negedge CLK);
        check("credit_freed", int'(req_ready_0), 1);
        tick();
        req_valid_0 = 0;
        check("credit_accepts_total", acc0 - base0, DEPTH + 1);
        rsp_ready_0 = 1;
        wait_idle();

        // Requester 1 fills its buffer and is starved of credit.
        base1 = acc1;
        req_a_1 = 16'h4000; req_b_1 = 16'h4000; exp1 = 16'h4400;
        rsp_ready_1 = 0; req_valid_1 = 1;
        repeat (5) tick();
        check("fill1_accepts", acc1 - base1, DEPTH);
        base0 = acc0;
        req_a_0 = 16'h4200; req_b_0 = 16'h3800; exp0 = 16'h3E00;
        rsp_ready_0 = 1; req_valid_0 = 1; starve_phase = 1;
        repeat (9) tick();
        starve_phase = 0; req_valid_0 = 0; req_valid_1 = 0;
        // Each grant holds credit for LAT+1 cycles: pattern grant,grant,idle.
        check("starve_accepts_0", acc0 - base0, 6);
        check("starve_accepts_1", acc1 - base1, DEPTH);
        rsp_ready_1 = 1;
        wait_idle();

        // Ordering through a full buffer: 3C00, 4400, 3E00.
        rsp_ready_0 = 0;
        issue0(16'h3C00, 16'h3C00, 16'h3C00);
        issue0(16'h4000, 16'h4000, 16'h4400);
        req_a_0 = 16'h4200; req_b_0 = 16'h3800; exp0 = 16'h3E00; req_valid_0 = 1;
        repeat (3) tick();
        @(negedge CLK);
        check("full_block", int'(req_ready_0), 0);
        check("full_rsp_valid", int'(rsp_valid_0), 1);
        tick();
        rsp_ready_0 = 1;
        issue0(16'h4200, 16'h3800, 16'h3E00);
        wait_idle();

        // Reset with one product in flight: it must never appear.
        issue0(16'h3C00, 16'h4000, 16'h4000);
        RESET = 1; req_valid_0 = 1; req_valid_1 = 1;
        @(negedge CLK);
        check("mid_rst_ready_0", int'(req_ready_0), 0);
        check("mid_rst_ready_1", int'(req_ready_1), 0);
        check("mid_rst_mul_a", int'(mul_a), 0);
        tick();
        RESET = 0; req_valid_0 = 0; req_valid_1 = 0;
        for (int k = 0; k < LAT + 2; k++) begin
            @(negedge CLK);
            check("post_rst_rsp_valid_0", int'(rsp_valid_0), 0);
            check("post_rst_rsp_valid_1", int'(rsp_valid_1), 0);
            check("post_rst_busy", int'(busy), 0);
        end
        tick();

        check("sb_empty_0", q0.size(), 0);
        check("sb_empty_1", q1.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no end of test expected completion");
        $fatal(1);
    end

endmodule
